tt_mux_ctrl: RTL and testbench

Controller at the initiator end of the project-select mux. It turns slow pad-level control strobes into a clean address and project enable for the mux.
- A reset strobe (sel_rst_n) and an increment strobe (sel_inc) step a wrapping project address.
- An enable request gates the selected project on.
- Every address change forces a blanking/settle window so the mux never drives a project mid-switch.

---
 rtl/tt_mux_ctrl.sv | 140 ++++++++++++++
 tb/tb_tt_mux_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_mux_ctrl.sv
// Project-select mux controller: synchronizes pad strobes, steps a wrapping
// project address and gates proj_ena behind a settle window on every change.
module tt_mux_ctrl #(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned NUM_PROJ      = 32,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel_rst_n,
    input  logic              sel_inc,
    input  logic              ena_req,
    output logic [ADDR_W-1:0] addr,
    output logic              proj_ena,
    output logic              settling
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PROJ - 1);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_SETTLE,
        ST_ENABLED
    } state_e;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] inc_sync_q;
    logic [SYNC_STAGES-1:0] ena_sync_q;
    logic                   rst_prev_q;
    logic                   inc_prev_q;
    logic                   ena_prev_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              proj_ena_q, proj_ena_d;
    logic              settling_q, settling_d;

    logic rst_s, inc_s, ena_s;
    logic inc_rise, ena_rise;
    logic enter_settle;

    assign rst_s    = rst_sync_q[SYNC_STAGES-1];
    assign inc_s    = inc_sync_q[SYNC_STAGES-1];
    assign ena_s    = ena_sync_q[SYNC_STAGES-1];
    assign inc_rise = inc_s & ~inc_prev_q;
    assign ena_rise = ena_s & ~ena_prev_q;

    // Synchronizer chains plus previous-value flops for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
            inc_sync_q <= '0;
            ena_sync_q <= '0;
            rst_prev_q <= 1'b0;
            inc_prev_q <= 1'b0;
            ena_prev_q <= 1'b0;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], sel_rst_n};
            inc_sync_q <= {inc_sync_q[SYNC_STAGES-2:0], sel_inc};
            ena_sync_q <= {ena_sync_q[SYNC_STAGES-2:0], ena_req};
            rst_prev_q <= rst_s;
            inc_prev_q <= inc_s;
            ena_prev_q <= ena_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DISABLED;
            cnt_q      <= '0;
            addr_q     <= '0;
            proj_ena_q <= 1'b0;
            settling_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            proj_ena_q <= proj_ena_d;
            settling_q <= settling_d;
        end
    end

    // Held select-reset dominates; any address change (including the
    // release of select-reset) restarts the settle window.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        enter_settle = 1'b0;

        if (!rst_s) begin
            state_d = ST_DISABLED;
            cnt_d   = '0;
            addr_d  = '0;
        end else if (!rst_prev_q) begin
            enter_settle = 1'b1;
        end else if (inc_rise) begin
            addr_d       = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
            enter_settle = 1'b1;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ena_s ? ST_ENABLED : ST_DISABLED;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DISABLED: begin
                    if (ena_rise) begin
                        enter_settle = 1'b1;
                    end
                end
                ST_ENABLED: begin
                    if (!ena_s) begin
                        state_d = ST_DISABLED;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end

        if (enter_settle) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_LOAD;
        end

        proj_ena_d = (state_d == ST_ENABLED);
        settling_d = (state_d == ST_SETTLE);
    end

    assign addr     = addr_q;
    assign proj_ena = proj_ena_q;
    assign settling = settling_q;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Bench for tt_mux_ctrl: directed scenarios plus random pad activity, all
// checked against a timestamp-based behavioural model of the controller.
module tb_tt_mux_ctrl;

    localparam int ADDR_W   = 5;
    localparam int NUM_PROJ = 32;
    localparam int SYNC     = 2;
    localparam int SETTLE   = 4;
    localparam int M_DIS    = 0;
    localparam int M_SET    = 1;
    localparam int M_EN     = 2;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              sel_rst_n = 1'b0;
    logic              sel_inc   = 1'b0;
    logic              ena_req   = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic              proj_ena;
    logic              settling;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tt_mux_ctrl #(
        .ADDR_W(ADDR_W), .NUM_PROJ(NUM_PROJ), .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel_rst_n(sel_rst_n), .sel_inc(sel_inc),
        .ena_req(ena_req), .addr(addr), .proj_ena(proj_ena), .settling(settling)
    );

    // Model: pad samples are kept per edge; an action at edge k sees the pad
    // as sampled SYNC edges earlier, and a window ends SETTLE edges after it starts.
    int unsigned m_addr;
    int          m_mode, m_start, m_edge;
    bit          q_rst[$], q_inc[$], q_ena[$];
    bit          cr, pr, ci, pi, ce, pe;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr = 0; m_mode = M_DIS; m_start = 0; m_edge = 0;
            q_rst.delete(); q_inc.delete(); q_ena.delete();
            for (int i = 0; i <= SYNC; i++) begin
                q_rst.push_back(1'b0); q_inc.push_back(1'b0); q_ena.push_back(1'b0);
            end
        end else begin
            m_edge++;
            cr = q_rst[SYNC-1]; pr = q_rst[SYNC];
            ci = q_inc[SYNC-1]; pi = q_inc[SYNC];
            ce = q_ena[SYNC-1]; pe = q_ena[SYNC];
            if (!cr) begin
                m_addr = 0; m_mode = M_DIS;
            end else if (!pr || (ci && !pi)) begin
                if (pr) m_addr = (m_addr + 1) % NUM_PROJ;
                m_mode = M_SET; m_start = m_edge;
            end else if (m_mode == M_SET) begin
                if (m_edge - m_start >= SETTLE) m_mode = ce ? M_EN : M_DIS;
            end else if (m_mode == M_DIS) begin
                if (ce && !pe) begin m_mode = M_SET; m_start = m_edge; end
            end else if (!ce) begin
                m_mode = M_DIS;
            end
            q_rst.push_front(sel_rst_n); void'(q_rst.pop_back());
            q_inc.push_front(sel_inc);   void'(q_inc.pop_back());
            q_ena.push_front(ena_req);   void'(q_ena.pop_back());
        end
    end

    task automatic test_reset();
        sel_rst_n = 1'b0; sel_inc = 1'b0; ena_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (addr !== '0 || proj_ena !== 1'b0 || settling !== 1'b0) begin
            bad++;
            $display("FAIL reset_assert addr=%0d ena=%0b set=%0b want 0/0/0", addr, proj_ena, settling);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (addr !== '0 || proj_ena !== 1'b0 || settling !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold addr=%0d ena=%0b set=%0b want 0/0/0", addr, proj_ena, settling);
            end
        end
    endtask

    task automatic test_release();
        sel_rst_n = 1'b1; ena_req = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            total++;
            if (addr !== '0 || settling !== (e >= 3 && e <= 6) || proj_ena !== (e >= 7)) begin
                bad++;
                $display("FAIL release edge=%0d addr=%0d ena=%0b set=%0b want 0/%0b/%0b",
                         e, addr, proj_ena, settling, (e >= 7), (e >= 3 && e <= 6));
            end
        end
    endtask

    task automatic test_single_inc();
        sel_inc = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            sel_inc = 1'b0;
            total++;
            if (addr !== ADDR_W'(e >= 3 ? 1 : 0) || settling !== (e >= 3 && e <= 6) ||
                proj_ena !== (e < 3 || e >= 7)) begin
                bad++;
                $display("FAIL single_inc edge=%0d addr=%0d ena=%0b set=%0b want %0d/%0b/%0b",
                         e, addr, proj_ena, settling, (e >= 3 ? 1 : 0), (e < 3 || e >= 7),
                         (e >= 3 && e <= 6));
            end
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] prev_addr;
        bit saw_wrap = 1'b0;
        int start_addr = int'(addr);
        prev_addr = addr;
        for (int p = 0; p < 32; p++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                total++;
                if (addr !== ADDR_W'(m_addr) || proj_ena !== (m_mode == M_EN) ||
                    settling !== (m_mode == M_SET)) begin
                    bad++;
                    $display("FAIL wrap_model addr=%0d ena=%0b set=%0b want %0d/%0b/%0b",
                             addr, proj_ena, settling, m_addr, (m_mode == M_EN), (m_mode == M_SET));
                end
                total++;
                if (proj_ena === 1'b1 && addr !== prev_addr) begin
                    bad++;
                    $display("FAIL wrap_overlap addr=%0d prev=%0d ena=%0b want ena 0", addr, prev_addr, proj_ena);
                end
                if (prev_addr == ADDR_W'(NUM_PROJ - 1) && addr == '0) saw_wrap = 1'b1;
                prev_addr = addr;
                sel_inc = (c == 0);
            end
        end
        total++;
        if (!saw_wrap || addr !== ADDR_W'((start_addr + 32) % NUM_PROJ)) begin
            bad++;
            $display("FAIL wrap_end saw_wrap=%0b addr=%0d want 1/%0d", saw_wrap, addr, (start_addr + 32) % NUM_PROJ);
        end
    endtask

    task automatic test_back_to_back();
        int start_addr = int'(addr);
        int first = -1, last = -1, cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            sel_inc = (e == 1 || e == 3);
            @(negedge clk);
            if (settling === 1'b1) begin
                if (first < 0) first = e;
                last = e; cnt++;
            end
            total++;
            if (addr !== ADDR_W'(m_addr) || proj_ena !== (m_mode == M_EN) ||
                settling !== (m_mode == M_SET)) begin
                bad++;
                $display("FAIL b2b_model edge=%0d addr=%0d ena=%0b set=%0b want %0d/%0b/%0b",
                         e, addr, proj_ena, settling, m_addr, (m_mode == M_EN), (m_mode == M_SET));
            end
        end
        sel_inc = 1'b0;
        total++;
        if (cnt != 6 || last - first + 1 != 6 || addr !== ADDR_W'((start_addr + 2) % NUM_PROJ)) begin
            bad++;
            $display("FAIL b2b_window high=%0d span=%0d addr=%0d want 6/6/%0d",
                     cnt, last - first + 1, addr, (start_addr + 2) % NUM_PROJ);
        end
    endtask

    task automatic test_sel_rst_drop();
        while (addr != ADDR_W'(7)) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                sel_inc = (c == 0);
            end
        end
        total++;
        if (addr !== ADDR_W'(7) || proj_ena !== 1'b1) begin
            bad++;
            $display("FAIL rstdrop_pre addr=%0d ena=%0b want 7/1", addr, proj_ena);
        end
        sel_rst_n = 1'b0; sel_inc = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            sel_inc = 1'b0;
            if (e >= 3) begin
                total++;
                if (addr !== '0 || proj_ena !== 1'b0 || settling !== 1'b0) begin
                    bad++;
                    $display("FAIL rstdrop edge=%0d addr=%0d ena=%0b set=%0b want 0/0/0",
                             e, addr, proj_ena, settling);
                end
            end
        end
        sel_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (addr !== '0 || proj_ena !== 1'b1) begin
            bad++;
            $display("FAIL rstdrop_recover addr=%0d ena=%0b want 0/1", addr, proj_ena);
        end
    endtask

    task automatic test_async_reset();
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < ((p == 4) ? 4 : 10); c++) begin
                @(negedge clk);
                sel_inc = (c == 0);
            end
        end
        total++;
        if (addr !== ADDR_W'(5) || settling !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre addr=%0d set=%0b want 5/1", addr, settling);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (addr !== '0 || proj_ena !== 1'b0 || settling !== 1'b0) begin
            bad++;
            $display("FAIL areset_now addr=%0d ena=%0b set=%0b want 0/0/0", addr, proj_ena, settling);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            total++;
            if (addr !== '0 || proj_ena !== (m_mode == M_EN) || settling !== (m_mode == M_SET)) begin
                bad++;
                $display("FAIL areset_after edge=%0d addr=%0d ena=%0b set=%0b want 0/%0b/%0b",
                         e, addr, proj_ena, settling, (m_mode == M_EN), (m_mode == M_SET));
            end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] prev_addr;
        prev_addr = addr;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            total++;
            if (addr !== ADDR_W'(m_addr) || proj_ena !== (m_mode == M_EN) ||
                settling !== (m_mode == M_SET)) begin
                bad++;
                $display("FAIL random cyc=%0d addr=%0d ena=%0b set=%0b want %0d/%0b/%0b",
                         c, addr, proj_ena, settling, m_addr, (m_mode == M_EN), (m_mode == M_SET));
            end
            total++;
            if (proj_ena === 1'b1 && addr !== prev_addr) begin
                bad++;
                $display("FAIL random_overlap cyc=%0d addr=%0d prev=%0d want ena 0", c, addr, prev_addr);
            end
            prev_addr = addr;
            sel_inc = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) ena_req = ~ena_req;
            if (sel_rst_n) begin
                if ($urandom_range(0, 59) == 0) sel_rst_n = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                sel_rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_release();
        test_single_inc();
        test_wrap();
        test_back_to_back();
        test_sel_rst_drop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
